bcd_countdown_timer: RTL
========================

Name: bcd_countdown_timer

Overview:
MM:SS BCD countdown timer. It is the down-counting counterpart of the clock's up-counting BCD digit chain. It has four BCD digits with borrow ripple, an internal 1 Hz prescaler and a run/pause/done control FSM. Its digit outputs feed the same 7-segment display path as the clock digits. Its done/expired flags drive the alarm logic.

Parameters:
CLK_DIV, 50_000_000, clock cycles per one-second decrement; minimum 2.

Ports:
clock  in  1  system clock, all state on its rising edge
reset_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear to 00:00 / IDLE
load  in  1  load the preset digits
start  in  1  start or resume the countdown
pause  in  1  pause the countdown
preset_min_tens  in  4  BCD preset, legal range 0-5
preset_min_units  in  4  BCD preset, legal range 0-9
preset_sec_tens  in  4  BCD preset, legal range 0-5
preset_sec_units  in  4  BCD preset, legal range 0-9
bcd_min_tens  out  4  current digit
bcd_min_units  out  4  current digit
bcd_sec_tens  out  4  current digit
bcd_sec_units  out  4  current digit
running  out  1  high in RUN
paused  out  1  high in PAUSE
done  out  1  one-cycle pulse on reaching 00:00
expired  out  1  high in DONE
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset_n low, asynchronous):
  - all digits 0; state IDLE; prescaler 0.
  - running, paused, done, expired and load_err all 0.
- Control priority per cycle: clear > load > pause/start.
- clear: accepted in any state. Next edge: digits 00:00, state IDLE, prescaler 0, expired 0.
- load:
  - Ignored in RUN.
  - In IDLE, PAUSE or DONE, every preset digit is range-checked.
  - All legal: next edge loads the digits, state goes to IDLE, prescaler goes to 0, expired goes to 0.
  - Any digit illegal: digits and state unchanged; load_err high for exactly one cycle.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE + start with digits nonzero -> RUN; prescaler cleared.
  - IDLE + start with digits 00:00 -> stay IDLE; no done pulse.
  - RUN + pause -> PAUSE; prescaler frozen. If start and pause are both high in RUN, pause wins.
  - PAUSE + start -> RUN; prescaler resumes from its frozen value. If start and pause are both high in PAUSE, start wins.
  - DONE: start and pause ignored; only load, clear or reset leave DONE.
- Prescaler: counts only in RUN, 0..CLK_DIV-1. The tick is the cycle where the count equals CLK_DIV-1; the count wraps to 0 on that edge.
- First decrement lands on the edge CLK_DIV cycles after the edge that entered RUN.
- Decrement on tick, as a borrow chain:
  - sec_units: 0 -> 9 with borrow, else -1.
  - sec_tens: decrements only on borrow-in; 0 -> 5 with borrow.
  - min_units: decrements only on borrow-in; 0 -> 9 with borrow.
  - min_tens: decrements only on borrow-in; never underflows in RUN because 00:00 is never ticked.
- Terminal condition: the tick that moves the digits from 00:01 to 00:00 also moves the state to DONE on the same edge.
  - done is registered high for that one following cycle.
  - expired stays high for as long as the state is DONE.
- Outputs: all registered; no combinational path from any input to any output.

Decomposition:
- timer_pkg:
  - state typedef (IDLE/RUN/PAUSE/DONE).
  - Digit-limit constants: UNITS_MAX=9, TENS_MAX=5.
  - Helper function digit_legal(value, max).
- Sub-module bcd_down_digit:
  - Parameter MAX.
  - Ports: clock, reset_n, clr, ld, ld_val[3:0], dec_in, q[3:0], borrow_out.
  - borrow_out = dec_in & (q==0).
  - Instantiated four times in a ripple chain.

Test Plan:
- CLK_DIV=4; load 01:00, start -> 4 cycles later 00:59. After 60 ticks (240 cycles) the digits read 00:00; done is high for exactly 1 cycle; expired stays high; running is 0.
- Load 10:00, start -> first tick gives 09:59. Load 59:59 from IDLE -> one tick gives 59:58; no illegal digit ever appears.
- preset_sec_tens=6 with load in IDLE holding 02:30 -> load_err pulses 1 cycle; digits stay 02:30; state stays IDLE.
- Load 00:05, start; 2 cycles after the second tick (digits 00:03) assert pause for 20 cycles -> digits hold 00:03 and paused is 1. Then start -> 00:02 arrives exactly 2 cycles later.
- Start with digits 00:00 -> state stays IDLE; done is never asserted. Load during RUN -> ignored, countdown continues.
- Pull reset_n low between clock edges while in RUN at 00:37 -> all outputs go to 0 immediately, without waiting for an edge. After reset_n rises, the timer stays IDLE until load/start.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types, digit limits and the preset range check for the BCD countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause,
      StDone
   } timer_state_e;

   localparam logic [3:0] UNITS_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX  = 4'd5;

   // A BCD digit is legal when it does not exceed the limit of its position.
   function automatic logic digit_legal(input logic [3:0] value, input logic [3:0] max);
      return value <= max;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MAX and raises borrow_out_o on the wrap.
module bcd_down_digit
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX = UNITS_MAX
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic       clr_i,
   input  logic       ld_i,
   input  logic [3:0] ld_val_i,
   input  logic       dec_in_i,
   output logic [3:0] q_o,
   output logic       borrow_out_o
);

   logic [3:0] q_d, q_q;

   // Next digit value: clear beats load beats decrement.
   always_comb begin
      q_d = q_q;
      if (clr_i) begin
         q_d = 4'd0;
      end else if (ld_i) begin
         q_d = ld_val_i;
      end else if (dec_in_i) begin
         q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
      end
   end

   // Digit register with asynchronous active-low reset.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         q_q <= 4'd0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o          = q_q;
   assign borrow_out_o = dec_in_i & (q_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: 1 Hz prescaler, four-digit borrow chain, run/pause/done FSM.
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned CLK_DIV = 50_000_000
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic       clear_i,
   input  logic       load_i,
   input  logic       start_i,
   input  logic       pause_i,
   input  logic [3:0] preset_min_tens_i,
   input  logic [3:0] preset_min_units_i,
   input  logic [3:0] preset_sec_tens_i,
   input  logic [3:0] preset_sec_units_i,
   output logic [3:0] bcd_min_tens_o,
   output logic [3:0] bcd_min_units_o,
   output logic [3:0] bcd_sec_tens_o,
   output logic [3:0] bcd_sec_units_o,
   output logic       running_o,
   output logic       paused_o,
   output logic       done_o,
   output logic       expired_o,
   output logic       load_err_o
);

   localparam int unsigned    CntW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

   timer_state_e   state_d, state_q;
   logic [CntW-1:0] cnt_d, cnt_q;
   logic           running_d, running_q;
   logic           paused_d, paused_q;
   logic           done_d, done_q;
   logic           expired_d, expired_q;
   logic           load_err_d, load_err_q;

   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic       borrow_su, borrow_st, borrow_mu, borrow_mt;
   logic       preset_legal, load_accept, tick, digits_zero, digits_one;

   assign preset_legal = digit_legal(preset_min_tens_i,  TENS_MAX)
                       & digit_legal(preset_min_units_i, UNITS_MAX)
                       & digit_legal(preset_sec_tens_i,  TENS_MAX)
                       & digit_legal(preset_sec_units_i, UNITS_MAX);

   // Loads are ignored while running; clear takes precedence.
   assign load_accept = !clear_i && load_i && (state_q != StRun) && preset_legal;

   // A pause arriving in the tick cycle freezes the prescaler, so no tick is taken.
   assign tick = (state_q == StRun) && !clear_i && !pause_i && (cnt_q == CntLast);

   assign digits_zero = (min_tens == 4'd0) && (min_units == 4'd0)
                     && (sec_tens == 4'd0) && (sec_units == 4'd0);
   assign digits_one  = (min_tens == 4'd0) && (min_units == 4'd0)
                     && (sec_tens == 4'd0) && (sec_units == 4'd1);

   bcd_down_digit #(.MAX(UNITS_MAX)) u_sec_units (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .clr_i        (clear_i),
      .ld_i         (load_accept),
      .ld_val_i     (preset_sec_units_i),
      .dec_in_i     (tick),
      .q_o          (sec_units),
      .borrow_out_o (borrow_su)
   );

   bcd_down_digit #(.MAX(TENS_MAX)) u_sec_tens (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .clr_i        (clear_i),
      .ld_i         (load_accept),
      .ld_val_i     (preset_sec_tens_i),
      .dec_in_i     (borrow_su),
      .q_o          (sec_tens),
      .borrow_out_o (borrow_st)
   );

   bcd_down_digit #(.MAX(UNITS_MAX)) u_min_units (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .clr_i        (clear_i),
      .ld_i         (load_accept),
      .ld_val_i     (preset_min_units_i),
      .dec_in_i     (borrow_st),
      .q_o          (min_units),
      .borrow_out_o (borrow_mu)
   );

   bcd_down_digit #(.MAX(TENS_MAX)) u_min_tens (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .clr_i        (clear_i),
      .ld_i         (load_accept),
      .ld_val_i     (preset_min_tens_i),
      .dec_in_i     (borrow_mu),
      .q_o          (min_tens),
      .borrow_out_o (borrow_mt)
   );

   // Next state, prescaler and flag values; priority is clear > load > pause/start.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      load_err_d = 1'b0;
      if (clear_i) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else if (load_i && (state_q != StRun)) begin
         if (preset_legal) begin
            state_d = StIdle;
            cnt_d   = '0;
         end else begin
            load_err_d = 1'b1;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i && !digits_zero) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end
            end
            StRun: begin
               if (pause_i) begin
                  state_d = StPause;
               end else begin
                  cnt_d = tick ? '0 : cnt_q + 1'b1;
                  // A min-tens borrow would mean ticking 00:00; treat it as expiry too.
                  if (tick && (digits_one || borrow_mt)) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end
            end
            StPause: begin
               if (start_i) begin
                  state_d = StRun;
               end
            end
            StDone: begin
               state_d = StDone;
            end
         endcase
      end
      running_d = (state_d == StRun);
      paused_d  = (state_d == StPause);
      expired_d = (state_d == StDone);
   end

   // Control state and registered status outputs.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         running_q  <= 1'b0;
         paused_q   <= 1'b0;
         done_q     <= 1'b0;
         expired_q  <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         running_q  <= running_d;
         paused_q   <= paused_d;
         done_q     <= done_d;
         expired_q  <= expired_d;
         load_err_q <= load_err_d;
      end
   end

   assign bcd_min_tens_o  = min_tens;
   assign bcd_min_units_o = min_units;
   assign bcd_sec_tens_o  = sec_tens;
   assign bcd_sec_units_o = sec_units;
   assign running_o       = running_q;
   assign paused_o        = paused_q;
   assign done_o          = done_q;
   assign expired_o       = expired_q;
   assign load_err_o      = load_err_q;

endmodule
